ls_arbiter: RTL and testbench
=============================

# ls_arbiter

Arbitrates the single-ported 32 KB local store between three requesters: the odd-pipe load/store unit (LS, port 0), the DMA/MFC engine (port 1) and instruction fetch (port 2). Each cycle it grants at most one quadword access and drives the registered command to the local-store macro. It tracks in-flight reads by requester and routes returned data back to the requester that issued the read. It sits between the pipeline's load/store stage and the memory array, and is the only master of the array's port.

## Interface
- `RD_LAT`, default 6: local-store read latency in cycles, measured from command issue to `ls_rdata` valid.
- `STARVE_LIMIT`, default 8: number of waiting cycles after which the DMA or fetch port outranks the LS port.
- `MAX_BURST`, default 8: maximum number of consecutive DMA grants under `dma_lock`.
- `clk` in 1: the single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in [2:0]: request valid, one bit per port.
- `we` in [2:0]: per-port write enable (1 = store, 0 = load).
- `addr` in [2:0][0:14]: per-port byte address. Bits [11:14] are ignored.
- `wdata` in [2:0][0:127]: per-port store data.
- `dma_lock` in 1: DMA requests back-to-back grants (burst).
- `gnt` out [2:0]: one-hot grant, combinational, same cycle as the request.
- `rvalid` out [2:0]: one-hot read-return strobe.
- `rdata` out [0:127]: read data, shared by all ports and qualified by `rvalid`.
- `ls_en` out 1: memory command valid.
- `ls_we` out 1: memory write enable.
- `ls_addr` out [0:14]: memory address, with bits [11:14] forced to 0.
- `ls_wdata` out [0:127]: memory write data.
- `ls_rdata` in [0:127]: memory read data, valid `RD_LAT` cycles after the command.

## Operation
- Requester rule: a port holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. The access is accepted in the cycle `gnt` is high.
- Priority, highest first:
  1. DMA burst lock is active.
  2. A starved port; if both DMA and fetch are starved, DMA wins.
  3. LS.
  4. Round-robin between DMA and fetch. The pointer toggles only when one of the two is granted. The pointer resets to DMA.
- Wait counters (DMA and fetch each, 4 bits):
  - Increment each cycle `req` is high and `gnt` is low.
  - Saturate at `STARVE_LIMIT`.
  - Clear on grant, and clear when `req` is low.
  - The port is starved while its counter equals `STARVE_LIMIT`.
- Burst lock:
  - The lock is active when `dma_lock` and `req[1]` are both high and the previous grant went to DMA with burst count < `MAX_BURST`.
  - The burst count increments on each DMA grant.
  - The count clears on any non-DMA grant, and clears when `req[1]` is low.
  - When the count reaches `MAX_BURST`, the lock is ignored until the count clears.
  - A starved fetch port is honoured only after the lock drops.
- Read-tag pipeline:
  - A shift register of depth `RD_LAT + 1` carries {valid, port id} for every granted load.
  - `rvalid[id]` is asserted for one cycle when the entry exits the pipeline.
  - `rdata` is `ls_rdata` passed through unregistered.
  - Stores enter no tag.
- There is no backpressure on returns. A requester must accept `rvalid` in every cycle.

## Timing
- Cycle N: `gnt` is asserted.
- Cycle N+1: registered `ls_en`, `ls_we`, `ls_addr` and `ls_wdata` are presented.
- Cycle N+1+`RD_LAT`: `rvalid` and `rdata` are presented for a load granted at N.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- All ports idle: `gnt` = 0 and, on the next cycle, `ls_en` = 0. `ls_addr` and `ls_wdata` hold their last values.
- Reset values: `gnt` 0, `rvalid` 0, `ls_en` 0, `ls_we` 0, `ls_addr` 0, `ls_wdata` 0. Counters, round-robin pointer and tag pipeline are all cleared.
- Reset mid-operation: in-flight reads are dropped and no `rvalid` follows. Requesters must reissue.
- Simultaneous events:
  - A starved port and a lock in the same cycle: the lock wins.
  - A counter reaching `STARVE_LIMIT` in the same cycle it is granted: the counter clears.

## Structure
- Shared package `spu_ls_pkg`:
  - Port-id enum (`LS`=0, `DMA`=1, `FETCH`=2).
  - Quadword address width (15) and data width (128).
  - Default `RD_LAT`.
- One sub-module, `ls_rd_tag_pipe`: a parameterised-depth shift register of {valid, id}, asynchronously cleared.
- Arbitration logic, counters and command register live in `ls_arbiter`.

## Test plan
- Only LS request, load at `addr`=0x0013: `gnt`=001 at N; `ls_addr`=0x0010 and `ls_we`=0 at N+1; `rvalid`=001 at N+7 with `rdata`=`ls_rdata`.
- LS and DMA both held continuously: LS granted 8 cycles, then DMA granted at cycle 9 (starved), then LS resumes.
- DMA and fetch continuously, LS idle: grants alternate 010, 100, 010, …, starting with DMA after reset.
- `dma_lock` held with LS and fetch requesting: exactly 8 consecutive DMA grants, then a non-DMA grant, then a new burst may start.
- Loads issued on three consecutive cycles from ports 0, 1, 2: `rvalid` = 001, 010, 100 on three consecutive cycles, each with the matching `rdata`.
- Reset asserted 3 cycles after a load grant: all outputs 0 immediately, and no `rvalid` occurs after reset is released.

Source files
------------

// File: rtl/spu_ls_pkg.sv
// Shared types and constants for the SPU local-store arbiter slice.
// Port ids, quadword geometry and the wait-counter update rule live here.
package spu_ls_pkg;

    typedef enum logic [1:0] {
        LS    = 2'd0,
        DMA   = 2'd1,
        FETCH = 2'd2
    } port_id_e;

    localparam int unsigned NUM_PORTS      = 3;
    localparam int unsigned QW_ADDR_W      = 15;
    localparam int unsigned QW_DATA_W      = 128;
    localparam int unsigned RD_LAT_DEFAULT = 6;
    localparam int unsigned WAIT_W         = 4;

    // Quadword alignment: the low four byte-address bits never reach the array.
    localparam logic [0:QW_ADDR_W-1] QW_ADDR_MASK = 15'h7ff0;

    function automatic port_id_e onehot_to_id(input logic [NUM_PORTS-1:0] oh);
        port_id_e id;
        case (oh)
            3'b010:  id = DMA;
            3'b100:  id = FETCH;
            default: id = LS;
        endcase
        return id;
    endfunction

    function automatic logic [WAIT_W-1:0] wait_next(input logic [WAIT_W-1:0] cnt,
                                                    input logic              req,
                                                    input logic              gnt,
                                                    input logic [WAIT_W-1:0] limit);
        if (!req || gnt) begin
            return '0;
        end
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/ls_rd_tag_pipe.sv
// Fixed-depth shift register of {valid, port id} tracking in-flight local-store reads.
// Cleared asynchronously so a reset drops every outstanding read.
module ls_rd_tag_pipe
    import spu_ls_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LAT_DEFAULT + 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    input  port_id_e in_id,
    output logic     out_valid,
    output port_id_e out_id
);

    logic [DEPTH-1:0] valid_q;
    port_id_e         id_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i] <= LS;
            end
        end else begin
            valid_q[0] <= in_valid;
            id_q[0]    <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/ls_arbiter.sv
// Three-way local-store arbiter (LS, DMA, fetch): grant selection, starvation and burst
// tracking, registered array command, and read-return routing by requester.
module ls_arbiter
    import spu_ls_pkg::*;
#(
    parameter int unsigned RD_LAT       = RD_LAT_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 req,
    input  logic [NUM_PORTS-1:0]                 we,
    input  logic [NUM_PORTS-1:0][0:QW_ADDR_W-1]  addr,
    input  logic [NUM_PORTS-1:0][0:QW_DATA_W-1]  wdata,
    input  logic                                 dma_lock,
    output logic [NUM_PORTS-1:0]                 gnt,
    output logic [NUM_PORTS-1:0]                 rvalid,
    output logic [0:QW_DATA_W-1]                 rdata,
    output logic                                 ls_en,
    output logic                                 ls_we,
    output logic [0:QW_ADDR_W-1]                 ls_addr,
    output logic [0:QW_DATA_W-1]                 ls_wdata,
    input  logic [0:QW_DATA_W-1]                 ls_rdata
);

    localparam logic [WAIT_W-1:0]  STARVE_CNT = WAIT_W'(STARVE_LIMIT);
    localparam int unsigned        BURST_W    = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_CNT  = BURST_W'(MAX_BURST);

    logic [WAIT_W-1:0]    dma_wait_q, dma_wait_d;
    logic [WAIT_W-1:0]    fetch_wait_q, fetch_wait_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic                 last_dma_q, last_dma_d;
    logic                 rr_fetch_q, rr_fetch_d;

    logic                 ls_en_q, ls_we_q;
    logic [0:QW_ADDR_W-1] ls_addr_q, ls_addr_d;
    logic [0:QW_DATA_W-1] ls_wdata_q;

    logic                 lock_active, dma_starved, fetch_starved;
    logic                 any_gnt;
    port_id_e             gnt_id;
    logic                 tag_valid;
    port_id_e             tag_id;

    // Grant selection
    always_comb begin
        lock_active   = dma_lock & req[DMA] & last_dma_q & (burst_q < BURST_CNT);
        dma_starved   = req[DMA] & (dma_wait_q == STARVE_CNT);
        fetch_starved = req[FETCH] & (fetch_wait_q == STARVE_CNT);
        gnt           = '0;
        // Combinational grant is held off while reset is applied.
        if (reset) begin
            gnt = '0;
        end else if (lock_active || dma_starved) begin
            gnt[DMA] = 1'b1;
        end else if (fetch_starved) begin
            gnt[FETCH] = 1'b1;
        end else if (req[LS]) begin
            gnt[LS] = 1'b1;
        end else if (req[DMA] && req[FETCH]) begin
            if (rr_fetch_q) begin
                gnt[FETCH] = 1'b1;
            end else begin
                gnt[DMA] = 1'b1;
            end
        end else if (req[DMA]) begin
            gnt[DMA] = 1'b1;
        end else if (req[FETCH]) begin
            gnt[FETCH] = 1'b1;
        end
    end

    assign any_gnt = |gnt;
    assign gnt_id  = onehot_to_id(gnt);

    // Next-state for counters, burst tracking and round-robin pointer
    always_comb begin
        dma_wait_d   = wait_next(dma_wait_q, req[DMA], gnt[DMA], STARVE_CNT);
        fetch_wait_d = wait_next(fetch_wait_q, req[FETCH], gnt[FETCH], STARVE_CNT);

        burst_d = burst_q;
        if (!req[DMA]) begin
            burst_d = '0;
        end else if (gnt[DMA]) begin
            // Saturate so a spent burst stays spent until a non-DMA grant clears it.
            burst_d = (burst_q >= BURST_CNT) ? BURST_CNT : burst_q + BURST_W'(1);
        end else if (any_gnt) begin
            burst_d = '0;
        end

        last_dma_d = any_gnt ? gnt[DMA] : last_dma_q;
        rr_fetch_d = (gnt[DMA] || gnt[FETCH]) ? ~rr_fetch_q : rr_fetch_q;
        ls_addr_d  = addr[gnt_id] & QW_ADDR_MASK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_wait_q   <= '0;
            fetch_wait_q <= '0;
            burst_q      <= '0;
            last_dma_q   <= 1'b0;
            rr_fetch_q   <= 1'b0;
            ls_en_q      <= 1'b0;
            ls_we_q      <= 1'b0;
            ls_addr_q    <= '0;
            ls_wdata_q   <= '0;
        end else begin
            dma_wait_q   <= dma_wait_d;
            fetch_wait_q <= fetch_wait_d;
            burst_q      <= burst_d;
            last_dma_q   <= last_dma_d;
            rr_fetch_q   <= rr_fetch_d;
            ls_en_q      <= any_gnt;
            ls_we_q      <= any_gnt & we[gnt_id];
            if (any_gnt) begin
                ls_addr_q  <= ls_addr_d;
                ls_wdata_q <= wdata[gnt_id];
            end
        end
    end

    assign ls_en    = ls_en_q;
    assign ls_we    = ls_we_q;
    assign ls_addr  = ls_addr_q;
    assign ls_wdata = ls_wdata_q;

    // One extra stage covers the command register in front of the array.
    ls_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (any_gnt & ~we[gnt_id]),
        .in_id     (gnt_id),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    always_comb begin
        rvalid = '0;
        if (tag_valid) begin
            rvalid[tag_id] = 1'b1;
        end
    end

    assign rdata = ls_rdata;

    gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    gnt_req_a: assert property (@(posedge clk) disable iff (reset) (gnt & ~req) == '0);
    rvalid_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(rvalid));
    lock_wins_a: assert property (@(posedge clk) disable iff (reset) lock_active |-> gnt[DMA]);

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed self-checking bench for ls_arbiter with a small local-store read model.
module tb_ls_arbiter;
    import spu_ls_pkg::*;

    localparam int unsigned RD_LAT = 6;

    logic             clk;
    logic             reset;
    logic [2:0]       req;
    logic [2:0]       we;
    logic [2:0][0:14] addr;
    logic [2:0][0:127] wdata;
    logic             dma_lock;
    logic [2:0]       gnt;
    logic [2:0]       rvalid;
    logic [0:127]     rdata;
    logic             ls_en;
    logic             ls_we;
    logic [0:14]      ls_addr;
    logic [0:127]     ls_wdata;
    logic [0:127]     ls_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    ls_arbiter #(
        .RD_LAT       (RD_LAT),
        .STARVE_LIMIT (8),
        .MAX_BURST    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .dma_lock (dma_lock),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ls_en    (ls_en),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:127] rd_pat(input logic [0:14] a);
        return {8{1'b1, a}};
    endfunction

    // Array model: a read command presented in cycle M returns data in cycle M + RD_LAT.
    logic        mp_v    [RD_LAT];
    logic [0:14] mp_addr [RD_LAT];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                mp_v[i]    <= 1'b0;
                mp_addr[i] <= '0;
            end
        end else begin
            mp_v[0]    <= ls_en & ~ls_we;
            mp_addr[0] <= ls_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                mp_v[i]    <= mp_v[i-1];
                mp_addr[i] <= mp_addr[i-1];
            end
        end
    end

    assign ls_rdata = mp_v[RD_LAT-1] ? rd_pat(mp_addr[RD_LAT-1]) : '0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset    = 1'b1;
        req      = '0;
        dma_lock = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Hand-derived grant sequence for LS+DMA+fetch requesting with dma_lock held.
    function automatic logic [2:0] burst_exp(input int i);
        if (i < 8)  return 3'b001;
        if (i < 16) return 3'b010;
        if (i == 16) return 3'b100;
        if (i < 24) return 3'b001;
        if (i < 32) return 3'b010;
        return 3'b100;
    endfunction

    logic [2:0] rv_seen;

    initial begin
        reset    = 1'b1;
        req      = 3'b111;
        we       = '0;
        addr     = '0;
        wdata    = '0;
        dma_lock = 1'b0;

        // Reset values, with requests pending
        @(negedge clk);
        check_eq("reset gnt", gnt, 3'b000);
        check_eq("reset rvalid", rvalid, 3'b000);
        check_eq("reset ls_en", ls_en, 1'b0);
        check_eq("reset ls_we", ls_we, 1'b0);
        check_eq("reset ls_addr", ls_addr, 15'h0);
        check_eq("reset ls_wdata", ls_wdata, 128'h0);
        step();
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        check_eq("idle gnt", gnt, 3'b000);

        // Single LS load, address 0x0013
        step();
        req     = 3'b001;
        we      = 3'b000;
        addr[0] = 15'h0013;
        @(negedge clk);
        check_eq("ls load gnt", gnt, 3'b001);
        step();
        req = '0;
        @(negedge clk);
        check_eq("ls load ls_en", ls_en, 1'b1);
        check_eq("ls load ls_we", ls_we, 1'b0);
        check_eq("ls load ls_addr", ls_addr, 15'h0010);
        repeat (5) @(negedge clk);
        check_eq("ls load rvalid early", rvalid, 3'b000);
        @(negedge clk);
        check_eq("ls load rvalid", rvalid, 3'b001);
        check_eq("ls load rdata", rdata, rd_pat(15'h0010));
        @(negedge clk);
        check_eq("ls load rvalid late", rvalid, 3'b000);

        // LS and DMA held: DMA starves after 8 LS grants
        step();
        req = 3'b011;
        we  = 3'b011;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq($sformatf("starve gnt[%0d]", i), gnt, (i == 8) ? 3'b010 : 3'b001);
            step();
        end
        req = '0;

        // DMA and fetch alternate from DMA after reset
        do_reset();
        req = 3'b110;
        we  = 3'b110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("rr gnt[%0d]", i), gnt, (i % 2 == 0) ? 3'b010 : 3'b100);
            step();
        end
        req = '0;

        // DMA burst lock with LS and fetch competing
        do_reset();
        dma_lock = 1'b1;
        req      = 3'b111;
        we       = 3'b111;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            check_eq($sformatf("burst gnt[%0d]", i), gnt, burst_exp(i));
            step();
        end
        req      = '0;
        dma_lock = 1'b0;

        // Loads from ports 0, 1, 2 on consecutive cycles
        do_reset();
        we      = 3'b000;
        addr[0] = 15'h0123;
        addr[1] = 15'h1a5f;
        addr[2] = 15'h7fff;
        req     = 3'b001;
        @(negedge clk);
        check_eq("seq gnt0", gnt, 3'b001);
        step();
        req = 3'b010;
        @(negedge clk);
        check_eq("seq gnt1", gnt, 3'b010);
        check_eq("seq ls_addr0", ls_addr, 15'h0120);
        step();
        req = 3'b100;
        @(negedge clk);
        check_eq("seq gnt2", gnt, 3'b100);
        check_eq("seq ls_addr1", ls_addr, 15'h1a50);
        step();
        req = 3'b000;
        @(negedge clk);
        check_eq("seq gnt idle", gnt, 3'b000);
        check_eq("seq ls_addr2", ls_addr, 15'h7ff0);
        @(negedge clk);
        check_eq("seq idle ls_en", ls_en, 1'b0);
        check_eq("seq idle ls_addr hold", ls_addr, 15'h7ff0);
        repeat (2) @(negedge clk);
        check_eq("seq rvalid early", rvalid, 3'b000);
        @(negedge clk);
        check_eq("seq rvalid0", rvalid, 3'b001);
        check_eq("seq rdata0", rdata, rd_pat(15'h0120));
        @(negedge clk);
        check_eq("seq rvalid1", rvalid, 3'b010);
        check_eq("seq rdata1", rdata, rd_pat(15'h1a50));
        @(negedge clk);
        check_eq("seq rvalid2", rvalid, 3'b100);
        check_eq("seq rdata2", rdata, rd_pat(15'h7ff0));
        @(negedge clk);
        check_eq("seq rvalid after", rvalid, 3'b000);

        // DMA store: command carries data, no read return
        step();
        req      = 3'b010;
        we       = 3'b010;
        addr[1]  = 15'h2345;
        wdata[1] = 128'h0123456789abcdef_fedcba9876543210;
        @(negedge clk);
        check_eq("store gnt", gnt, 3'b010);
        step();
        req = '0;
        @(negedge clk);
        check_eq("store ls_en", ls_en, 1'b1);
        check_eq("store ls_we", ls_we, 1'b1);
        check_eq("store ls_addr", ls_addr, 15'h2340);
        check_eq("store ls_wdata", ls_wdata, 128'h0123456789abcdef_fedcba9876543210);
        @(negedge clk);
        check_eq("store idle ls_en", ls_en, 1'b0);
        check_eq("store ls_wdata hold", ls_wdata, 128'h0123456789abcdef_fedcba9876543210);
        rv_seen = '0;
        repeat (10) begin
            @(negedge clk);
            rv_seen = rv_seen | rvalid;
        end
        check_eq("store no rvalid", rv_seen, 3'b000);

        // Reset three cycles after a load grant drops the read
        step();
        req      = 3'b001;
        we       = 3'b000;
        addr[0]  = 15'h0040;
        wdata[0] = 128'ha5a5;
        @(negedge clk);
        check_eq("rst load gnt", gnt, 3'b001);
        step();
        req = '0;
        @(negedge clk);
        check_eq("rst load ls_en", ls_en, 1'b1);
        check_eq("rst load ls_addr", ls_addr, 15'h0040);
        step();
        step();
        reset = 1'b1;
        req   = 3'b001;
        #1;
        check_eq("midrst gnt", gnt, 3'b000);
        check_eq("midrst rvalid", rvalid, 3'b000);
        check_eq("midrst ls_en", ls_en, 1'b0);
        check_eq("midrst ls_we", ls_we, 1'b0);
        check_eq("midrst ls_addr", ls_addr, 15'h0);
        check_eq("midrst ls_wdata", ls_wdata, 128'h0);
        step();
        step();
        reset = 1'b0;
        req   = '0;
        rv_seen = '0;
        repeat (12) begin
            @(negedge clk);
            rv_seen = rv_seen | rvalid;
        end
        check_eq("midrst no rvalid", rv_seen, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
